// File: rtl/nzp_cc_unit.sv
// nzp_cc_unit: registered LC-3 condition codes with branch-enable evaluation
// and a one-entry shadow copy of CC used across interrupt entry/return.
// All outputs come straight from flops; nothing combinational reaches a port.
module nzp_cc_unit #(
    parameter int WIDTH   = 16,
    parameter bit SIGNED  = 1'b1,
    parameter bit FORWARD = 1'b0
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic [WIDTH-1:0] D_in,
    input  logic             LD_CC,
    input  logic [2:0]       IR_nzp,
    input  logic             LD_BEN,
    input  logic             SAVE_CC,
    input  logic             RESTORE_CC,
    output logic [2:0]       CC_out,
    output logic [2:0]       CC_saved,
    output logic             BEN,
    output logic             BEN_valid
);

    if (WIDTH < 2) begin : g_width_check
        $error("nzp_cc_unit: WIDTH must be at least 2");
    end

    logic [2:0] cc_decode;
    logic [2:0] cc_next;
    logic [2:0] cc_eval;
    logic       ben_next;

    // One-hot sign/zero decode of D_in; the sign only counts for two's complement data.
    always_comb begin
        cc_decode = 3'b001;
        if (SIGNED && D_in[WIDTH-1]) begin
            cc_decode = 3'b100;
        end else if (D_in == '0) begin
            cc_decode = 3'b010;
        end
    end

    // CC next state: restore from shadow beats a fresh load, otherwise hold.
    always_comb begin
        cc_next = CC_out;
        if (RESTORE_CC) begin
            cc_next = CC_saved;
        end else if (LD_CC) begin
            cc_next = cc_decode;
        end
    end

    // Branch condition is evaluated either against the current or the incoming CC.
    always_comb begin
        cc_eval  = FORWARD ? cc_next : CC_out;
        ben_next = |(IR_nzp & cc_eval);
    end

    // State update; shadow always captures the pre-update CC, which makes
    // simultaneous save+restore a swap.
    always_ff @(posedge Clk) begin
        if (!Reset) begin
            CC_out    <= 3'b010;
            CC_saved  <= 3'b010;
            BEN       <= 1'b0;
            BEN_valid <= 1'b0;
        end else begin
            CC_out    <= cc_next;
            if (SAVE_CC) begin
                CC_saved <= CC_out;
            end
            if (LD_BEN) begin
                BEN <= ben_next;
            end
            BEN_valid <= LD_BEN;
        end
    end

endmodule

// File: tb/tb_nzp_cc_unit.sv
// Bench for nzp_cc_unit: three parameterisations driven in lockstep, each
// compared every cycle against an arithmetic reference model, plus directed
// expectations for the documented scenarios.
module tb_nzp_cc_unit;

    logic        Clk = 1'b0;
    logic        Reset;
    logic [15:0] D_in;
    logic        LD_CC;
    logic [2:0]  IR_nzp;
    logic        LD_BEN;
    logic        SAVE_CC;
    logic        RESTORE_CC;

    logic [2:0]  cc_o    [3];
    logic [2:0]  saved_o [3];
    logic        ben_o   [3];
    logic        bv_o    [3];

    int checks   = 0;
    int failures = 0;

    // instance parameters: {width, signed, forward}
    int pw [3];
    bit ps [3];
    bit pf [3];

    // reference model state
    logic [2:0] m_cc    [3];
    logic [2:0] m_saved [3];
    logic       m_ben   [3];
    logic       m_bv    [3];

    always #5 Clk = ~Clk;

    nzp_cc_unit #(.WIDTH(16), .SIGNED(1'b1), .FORWARD(1'b0)) u0 (
        .Clk(Clk), .Reset(Reset), .D_in(D_in), .LD_CC(LD_CC), .IR_nzp(IR_nzp),
        .LD_BEN(LD_BEN), .SAVE_CC(SAVE_CC), .RESTORE_CC(RESTORE_CC),
        .CC_out(cc_o[0]), .CC_saved(saved_o[0]), .BEN(ben_o[0]), .BEN_valid(bv_o[0])
    );

    nzp_cc_unit #(.WIDTH(16), .SIGNED(1'b0), .FORWARD(1'b1)) u1 (
        .Clk(Clk), .Reset(Reset), .D_in(D_in), .LD_CC(LD_CC), .IR_nzp(IR_nzp),
        .LD_BEN(LD_BEN), .SAVE_CC(SAVE_CC), .RESTORE_CC(RESTORE_CC),
        .CC_out(cc_o[1]), .CC_saved(saved_o[1]), .BEN(ben_o[1]), .BEN_valid(bv_o[1])
    );

    nzp_cc_unit #(.WIDTH(2), .SIGNED(1'b1), .FORWARD(1'b1)) u2 (
        .Clk(Clk), .Reset(Reset), .D_in(D_in[1:0]), .LD_CC(LD_CC), .IR_nzp(IR_nzp),
        .LD_BEN(LD_BEN), .SAVE_CC(SAVE_CC), .RESTORE_CC(RESTORE_CC),
        .CC_out(cc_o[2]), .CC_saved(saved_o[2]), .BEN(ben_o[2]), .BEN_valid(bv_o[2])
    );

    // Sign/zero classification done on the numeric value of the low w bits.
    function automatic logic [2:0] classify(int w, bit s, logic [15:0] d);
        longint v;
        longint half;
        v    = longint'(d) % (longint'(1) << w);
        half = longint'(1) << (w - 1);
        if (v == 0) return 3'b010;
        if (s && v >= half) return 3'b100;
        return 3'b001;
    endfunction

    task automatic check(string tag, int idx, logic [2:0] obs, logic [2:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s[u%0d] observed=%b expected=%b", tag, idx, obs, exp);
        end
    endtask

    task automatic drive(logic rst, logic ldcc, logic [15:0] d, logic ldben,
                         logic [2:0] nzp, logic save, logic restore);
        Reset      = rst;
        LD_CC      = ldcc;
        D_in       = d;
        LD_BEN     = ldben;
        IR_nzp     = nzp;
        SAVE_CC    = save;
        RESTORE_CC = restore;
    endtask

    // Advance one clock, update the model with the applied inputs, compare all instances.
    task automatic tick();
        logic [2:0] nxt;
        logic [2:0] eval;
        @(posedge Clk);
        for (int i = 0; i < 3; i++) begin
            if (!Reset) begin
                m_cc[i]    = 3'b010;
                m_saved[i] = 3'b010;
                m_ben[i]   = 1'b0;
                m_bv[i]    = 1'b0;
            end else begin
                if (RESTORE_CC)  nxt = m_saved[i];
                else if (LD_CC)  nxt = classify(pw[i], ps[i], D_in);
                else             nxt = m_cc[i];
                eval = pf[i] ? nxt : m_cc[i];
                if (LD_BEN) m_ben[i] = ((IR_nzp & eval) != 3'b000);
                m_bv[i] = LD_BEN;
                if (SAVE_CC) m_saved[i] = m_cc[i];
                m_cc[i] = nxt;
            end
        end
        #1;
        for (int i = 0; i < 3; i++) begin
            check("cc_out",    i, cc_o[i],            m_cc[i]);
            check("cc_saved",  i, saved_o[i],         m_saved[i]);
            check("ben",       i, {2'b00, ben_o[i]},  {2'b00, m_ben[i]});
            check("ben_valid", i, {2'b00, bv_o[i]},   {2'b00, m_bv[i]});
        end
    endtask

    initial begin
        pw[0] = 16; ps[0] = 1'b1; pf[0] = 1'b0;
        pw[1] = 16; ps[1] = 1'b0; pf[1] = 1'b1;
        pw[2] = 2;  ps[2] = 1'b1; pf[2] = 1'b1;
        for (int i = 0; i < 3; i++) begin
            m_cc[i] = 3'b010; m_saved[i] = 3'b010; m_ben[i] = 1'b0; m_bv[i] = 1'b0;
        end
        drive(1'b0, 1'b0, 16'h0, 1'b0, 3'b000, 1'b0, 1'b0);

        // reset for two cycles, then first BEN evaluation with z mask
        tick(); tick();
        check("rst_cc",    0, cc_o[0],    3'b010);
        check("rst_saved", 0, saved_o[0], 3'b010);
        check("rst_ben",   0, {2'b00, ben_o[0]}, 3'b000);
        check("rst_bv",    0, {2'b00, bv_o[0]},  3'b000);
        drive(1'b1, 1'b0, 16'h0, 1'b0, 3'b000, 1'b0, 1'b0);
        tick();
        drive(1'b1, 1'b0, 16'h0, 1'b1, 3'b010, 1'b0, 1'b0);
        tick();
        check("post_rst_ben", 0, {2'b00, ben_o[0]}, 3'b001);
        check("post_rst_bv",  0, {2'b00, bv_o[0]},  3'b001);
        drive(1'b1, 1'b0, 16'h0, 1'b0, 3'b000, 1'b0, 1'b0);
        tick();
        check("bv_pulse_end", 0, {2'b00, bv_o[0]}, 3'b000);

        // decode sequence
        drive(1'b1, 1'b1, 16'h8000, 1'b0, 3'b000, 1'b0, 1'b0);
        tick();
        check("dec_8000_signed",   0, cc_o[0], 3'b100);
        check("dec_8000_unsigned", 1, cc_o[1], 3'b001);
        drive(1'b1, 1'b1, 16'h0000, 1'b0, 3'b000, 1'b0, 1'b0);
        tick();
        check("dec_0000", 0, cc_o[0], 3'b010);
        drive(1'b1, 1'b1, 16'h7FFF, 1'b0, 3'b000, 1'b0, 1'b0);
        tick();
        check("dec_7fff", 0, cc_o[0], 3'b001);

        // forwarding: CC=001, then load FFFF with BEN mask p
        drive(1'b1, 1'b1, 16'h0001, 1'b0, 3'b000, 1'b0, 1'b0);
        tick();
        drive(1'b1, 1'b1, 16'hFFFF, 1'b1, 3'b001, 1'b0, 1'b0);
        tick();
        check("fwd0_ben", 0, {2'b00, ben_o[0]}, 3'b001);
        check("fwd0_cc",  0, cc_o[0], 3'b100);
        check("fwd1_ben", 2, {2'b00, ben_o[2]}, 3'b000);
        check("fwd1_cc",  2, cc_o[2], 3'b100);

        // save with load, then restore beats load
        drive(1'b1, 1'b1, 16'h0001, 1'b0, 3'b000, 1'b0, 1'b0);
        tick();
        drive(1'b1, 1'b1, 16'h0000, 1'b0, 3'b000, 1'b1, 1'b0);
        tick();
        check("save_saved", 0, saved_o[0], 3'b001);
        check("save_cc",    0, cc_o[0],    3'b010);
        drive(1'b1, 1'b1, 16'h8000, 1'b0, 3'b000, 1'b0, 1'b1);
        tick();
        check("restore_wins", 0, cc_o[0], 3'b001);

        // swap: CC=100, saved=010
        drive(1'b0, 1'b0, 16'h0, 1'b0, 3'b000, 1'b0, 1'b0);
        tick();
        drive(1'b1, 1'b1, 16'h8000, 1'b0, 3'b000, 1'b0, 1'b0);
        tick();
        drive(1'b1, 1'b0, 16'h0, 1'b0, 3'b000, 1'b1, 1'b1);
        tick();
        check("swap_cc",    0, cc_o[0],    3'b010);
        check("swap_saved", 0, saved_o[0], 3'b100);

        // reset discards simultaneous load/save/BEN
        drive(1'b1, 1'b1, 16'h0001, 1'b1, 3'b111, 1'b0, 1'b0);
        tick();
        drive(1'b0, 1'b1, 16'h8000, 1'b1, 3'b111, 1'b1, 1'b0);
        tick();
        check("rst_ovr_cc",    0, cc_o[0],    3'b010);
        check("rst_ovr_saved", 0, saved_o[0], 3'b010);
        check("rst_ovr_ben",   0, {2'b00, ben_o[0]}, 3'b000);
        check("rst_ovr_bv",    0, {2'b00, bv_o[0]},  3'b000);

        // mask sweep against each CC value
        for (int c = 0; c < 3; c++) begin
            logic [15:0] dv;
            logic [2:0]  ccv;
            dv  = (c == 0) ? 16'h8000 : ((c == 1) ? 16'h0000 : 16'h0001);
            ccv = (c == 0) ? 3'b100   : ((c == 1) ? 3'b010   : 3'b001);
            drive(1'b1, 1'b1, dv, 1'b0, 3'b000, 1'b0, 1'b0);
            tick();
            for (int m = 0; m < 8; m++) begin
                logic [2:0] mk;
                mk = 3'(m);
                drive(1'b1, 1'b0, 16'h0, 1'b1, mk, 1'b0, 1'b0);
                tick();
                check("sweep_ben", 0, {2'b00, ben_o[0]},
                      {2'b00, ((mk & ccv) != 3'b000)});
            end
        end

        // randomized traffic, all instances checked against the model each cycle
        for (int n = 0; n < 400; n++) begin
            logic [15:0] rd;
            case ($urandom_range(0, 3))
                0:       rd = 16'h0000;
                1:       rd = 16'h8000 | 16'($urandom);
                default: rd = 16'($urandom);
            endcase
            drive(($urandom_range(0, 31) != 0), 1'($urandom), rd, 1'($urandom),
                  3'($urandom), ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0));
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/nzp_cc_unit.md
Name: nzp_cc_unit

Overview:
Parametrised condition-code unit for the LC-3 datapath, replacing the purely combinational NZP decode. It does three things:
- Holds the registered N/Z/P flags under LD_CC.
- Evaluates and registers the branch-enable (BEN) under LD_BEN.
- Keeps a one-entry shadow copy of CC for interrupt entry/return (PSR save/restore).
It sits between the bus/ALU result and the control FSM.

Parameters:
WIDTH, 16, data width of D_in; legal range >= 2.
SIGNED, 1, 1: D_in is two's complement (MSB=1 gives N). 0: unsigned (N never set).
FORWARD, 0, 1: a BEN load in the same cycle as a CC update evaluates the new CC. 0: it evaluates the current registered CC.

Ports:
Clk  in  1  system clock, all state on rising edge.
Reset  in  1  synchronous, active-low; sampled on the rising edge of Clk.
D_in  in  WIDTH  value whose sign/zero status is captured.
LD_CC  in  1  load CC from decode of D_in.
IR_nzp  in  3  branch condition mask {n,z,p} from IR[11:9].
LD_BEN  in  1  load BEN register.
SAVE_CC  in  1  copy CC into shadow register.
RESTORE_CC  in  1  load CC from shadow register.
CC_out  out  3  registered {N,Z,P}.
CC_saved  out  3  shadow register contents.
BEN  out  1  registered branch enable.
BEN_valid  out  1  one-cycle pulse marking BEN freshly loaded.

Behaviour:
- Decode (combinational, internal):
  - SIGNED=1: MSB=1 gives 100; all bits zero gives 010; otherwise 001.
  - SIGNED=0: all bits zero gives 010; otherwise 001.
  - The decode is always one-hot.
- Reset (Reset=0 at a rising edge):
  - CC_out=010, CC_saved=010, BEN=0, BEN_valid=0.
  - Reset overrides every other input in that cycle.
- CC next-state priority:
  - RESTORE_CC=1: CC takes CC_saved. LD_CC is ignored that cycle.
  - Else LD_CC=1: CC takes the decode of D_in.
  - Else CC holds.
- Shadow register:
  - SAVE_CC=1: CC_saved takes the current registered CC_out, i.e. the pre-update value, even if LD_CC is also asserted.
  - Otherwise CC_saved holds.
- SAVE_CC and RESTORE_CC together: swap. CC takes the old CC_saved; CC_saved takes the old CC_out.
- BEN:
  - LD_BEN=1: BEN takes OR of (IR_nzp AND cc_eval).
  - FORWARD=0: cc_eval = current CC_out.
  - FORWARD=1: cc_eval = CC next-state, including RESTORE and LD_CC.
  - LD_BEN=0: BEN holds.
- BEN_valid: registered copy of LD_BEN. It is high exactly the cycle after each LD_BEN. Back-to-back LD_BEN keeps it high continuously.
- Latency:
  - CC_out and BEN are visible 1 cycle after the load edge.
  - There is no combinational path from inputs to outputs.
- IR_nzp=000 always yields BEN=0. IR_nzp=111 always yields BEN=1 (CC is one-hot).
- Reset mid-operation:
  - Pending LD/SAVE/RESTORE in the reset cycle are discarded.
  - The first post-reset BEN evaluation with IR_nzp=010 returns 1.
- Width rule: the zero test covers all WIDTH bits. The sign test uses bit WIDTH-1 only.

Test Plan:
1. Reset=0 for 2 cycles, then release -> CC_out=010, CC_saved=010, BEN=0, BEN_valid=0. Then LD_BEN with IR_nzp=010 -> next cycle BEN=1, BEN_valid=1, then BEN_valid=0.
2. WIDTH=16, SIGNED=1, LD_CC with D_in=16'h8000, 16'h0000, 16'h7FFF on successive cycles -> CC_out=100, 010, 001, each one cycle after its load. Repeat with SIGNED=0 and D_in=16'h8000 -> CC_out=001.
3. FORWARD=0: CC=001, assert LD_CC (D_in=16'hFFFF) and LD_BEN (IR_nzp=001) in the same cycle -> BEN=1, CC_out=100. FORWARD=1, same stimulus -> BEN=0, CC_out=100.
4. Save/restore sequence, starting from CC=001:
   - SAVE_CC together with LD_CC (D_in=0) -> CC_saved=001, CC_out=010.
   - Then RESTORE_CC together with LD_CC (D_in=16'h8000) -> CC_out=001 (restore wins).
5. CC=100, CC_saved=010, assert SAVE_CC and RESTORE_CC together -> CC_out=010, CC_saved=100.
6. Reset=0 asserted in the same cycle as LD_CC (D_in=16'h8000), SAVE_CC and LD_BEN (IR_nzp=111) -> CC_out=010, CC_saved=010, BEN=0, BEN_valid=0. Then sweep all 8 IR_nzp masks against each CC value -> BEN matches OR(mask AND CC) in all 24 cases.
